// File: rtl/stream_cipher_core.sv
// rtl/stream_cipher_core.sv - LFSR keystream XOR cipher with ready/valid streams and rekey expiry
module stream_cipher_core #(
   parameter int                DATA_W      = 8,
   parameter int                LFSR_W      = 32,
   parameter logic [LFSR_W-1:0] POLY        = 32'h8020_0003,
   parameter int                REKEY_LIMIT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_load,
   input  logic [LFSR_W-1:0] key,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              keyed,
   output logic              expired,
   output logic [15:0]       word_count
);

   typedef enum logic [1:0] {
      S_UNKEYED = 2'd0,
      S_KEYED   = 2'd1,
      S_EXPIRED = 2'd2
   } state_t;

   localparam logic [15:0] LIMIT = 16'(REKEY_LIMIT);

   state_t              state_q;
   logic [LFSR_W-1:0]   lfsr_q;
   logic [LFSR_W-1:0]   lfsr_d;
   logic                out_valid_q;
   logic [DATA_W-1:0]   out_data_q;
   logic [15:0]         count_q;
   logic [15:0]         count_d;
   logic                accept;

   // Advance the Galois LFSR by DATA_W single-bit steps so one word of keystream is consumed per accept
   function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] s);
      logic [LFSR_W-1:0] t;
      t = s;
      for (int i = 0; i < DATA_W; i++) begin
         if (t[0]) begin
            t = (t >> 1) ^ POLY;
         end else begin
            t = t >> 1;
         end
      end
      return t;
   endfunction

   // Next keystream state and saturating word counter for the accept path
   always_comb begin
      lfsr_d  = lfsr_advance(lfsr_q);
      count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
   end

   assign keyed      = (state_q == S_KEYED);
   assign expired    = (state_q == S_EXPIRED);
   assign in_ready   = keyed && (!out_valid_q || out_ready) && !key_load;
   assign accept     = in_valid && in_ready;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign word_count = count_q;

   // Key state machine, keystream register and single-entry output stage; reset beats key_load beats handshakes
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_UNKEYED;
         lfsr_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         count_q     <= '0;
      end else if (key_load) begin
         // An all-zero seed would lock the LFSR at zero forever, so substitute 1
         state_q     <= S_KEYED;
         lfsr_q      <= (key == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : key;
         out_valid_q <= 1'b0;
         count_q     <= '0;
      end else if (accept) begin
         out_data_q  <= in_data ^ lfsr_q[DATA_W-1:0];
         out_valid_q <= 1'b1;
         lfsr_q      <= lfsr_d;
         count_q     <= count_d;
         if (REKEY_LIMIT > 0 && count_d == LIMIT) begin
            state_q <= S_EXPIRED;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stream_cipher_core.sv
// tb/tb_stream_cipher_core.sv - self-checking bench for stream_cipher_core
module tb_stream_cipher_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        a_key_load = 1'b0;
   logic [31:0] a_key = '0;
   logic        a_in_valid = 1'b0;
   logic [7:0]  a_in_data = '0;
   logic        a_out_ready_tb = 1'b0;
   logic        chain = 1'b0;
   logic        a_out_ready;
   logic        a_in_ready, a_out_valid, a_keyed, a_expired;
   logic [7:0]  a_out_data;
   logic [15:0] a_wc;

   logic        b_key_load = 1'b0;
   logic [31:0] b_key = '0;
   logic        b_in_ready, b_out_valid, b_keyed, b_expired;
   logic [7:0]  b_out_data;
   logic [15:0] b_wc;

   logic        r_key_load = 1'b0;
   logic [31:0] r_key = '0;
   logic        r_in_valid = 1'b0;
   logic [7:0]  r_in_data = '0;
   logic        r_out_ready = 1'b0;
   logic        r_in_ready, r_out_valid, r_keyed, r_expired;
   logic [7:0]  r_out_data;
   logic [15:0] r_wc;

   int tests = 0;
   int fails = 0;

   // reference model state for instance A
   logic [31:0] m_s;
   logic        m_keyed, m_ov;
   logic [7:0]  m_od;
   int          m_cnt;

   always #5 clk = ~clk;

   assign a_out_ready = chain ? b_in_ready : a_out_ready_tb;

   stream_cipher_core dut_a (
      .clk(clk), .rst(rst), .key_load(a_key_load), .key(a_key),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .keyed(a_keyed), .expired(a_expired), .word_count(a_wc)
   );

   stream_cipher_core dut_b (
      .clk(clk), .rst(rst), .key_load(b_key_load), .key(b_key),
      .in_valid(a_out_valid), .in_ready(b_in_ready), .in_data(a_out_data),
      .out_valid(b_out_valid), .out_ready(1'b1), .out_data(b_out_data),
      .keyed(b_keyed), .expired(b_expired), .word_count(b_wc)
   );

   stream_cipher_core #(.REKEY_LIMIT(4)) dut_r (
      .clk(clk), .rst(rst), .key_load(r_key_load), .key(r_key),
      .in_valid(r_in_valid), .in_ready(r_in_ready), .in_data(r_in_data),
      .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data),
      .keyed(r_keyed), .expired(r_expired), .word_count(r_wc)
   );

   // one keystream word: eight single-bit Galois steps
   function automatic logic [31:0] ks_next(input logic [31:0] s);
      logic [31:0] t;
      logic        b;
      t = s;
      for (int i = 0; i < 8; i++) begin
         b = t[0];
         t = t >> 1;
         if (b) t = t ^ 32'h8020_0003;
      end
      return t;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // key load on instance A, with model update
   task automatic load_a(input logic [31:0] k);
      a_key_load = 1'b1;
      a_key = k;
      a_in_valid = 1'b1;
      #1;
      chk("keyload_in_ready", a_in_ready, 0);
      tick();
      a_key_load = 1'b0;
      a_in_valid = 1'b0;
      m_keyed = 1'b1;
      m_ov = 1'b0;
      m_cnt = 0;
      m_s = (k == 0) ? 32'd1 : k;
      chk("keyload_keyed", a_keyed, 1);
      chk("keyload_out_valid", a_out_valid, 0);
      chk("keyload_wc", a_wc, 0);
   endtask

   // one cycle on instance A against the model
   task automatic cyc(input logic v, input logic [7:0] d, input logic r);
      logic exp_rdy;
      a_in_valid = v;
      a_in_data = d;
      a_out_ready_tb = r;
      #1;
      exp_rdy = m_keyed && (!m_ov || r);
      chk("in_ready", a_in_ready, exp_rdy);
      if (v && exp_rdy) begin
         m_od = d ^ m_s[7:0];
         m_s = ks_next(m_s);
         m_ov = 1'b1;
         m_cnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
      end else if (m_ov && r) begin
         m_ov = 1'b0;
      end
      tick();
      chk("out_valid", a_out_valid, m_ov);
      if (m_ov) chk("out_data", a_out_data, m_od);
      chk("word_count", a_wc, m_cnt);
   endtask

   initial begin
      logic [7:0]  words[16];
      logic [7:0]  got[$];
      logic [31:0] rs;
      logic [7:0]  rexp;
      int          idx;
      int          acc;
      int          bound;

      m_s = '0; m_keyed = 1'b0; m_ov = 1'b0; m_od = '0; m_cnt = 0;

      // reset state
      tick();
      tick();
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_out_data", a_out_data, 0);
      chk("rst_wc", a_wc, 0);
      chk("rst_in_ready", a_in_ready, 0);
      chk("rst_keyed", a_keyed, 0);
      chk("rst_expired", a_expired, 0);
      rst = 1'b0;
      tick();

      // first word, fixed key
      load_a(32'hA5A5_5A5A);
      cyc(1'b1, 8'h00, 1'b0);
      chk("first_word_5A", a_out_data, 8'h5A);
      chk("first_word_wc", a_wc, 1);

      // back-pressure for five cycles, then one word per cycle
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'($urandom), 1'b0);
      chk("stall_data_stable", a_out_data, 8'h5A);
      for (int i = 0; i < 8; i++) cyc(1'b1, 8'($urandom), 1'b1);
      chk("stream_wc", a_wc, 9);
      cyc(1'b0, 8'h00, 1'b1);

      // random handshakes
      for (int i = 0; i < 150; i++)
         cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

      // key_load with a pending stalled word, zero key substitution
      cyc(1'b1, 8'($urandom), 1'b0);
      cyc(1'b1, 8'($urandom), 1'b0);
      load_a(32'h0);
      cyc(1'b1, 8'hFF, 1'b0);
      chk("zero_key_FE", a_out_data, 8'hFE);

      // reset with a pending stalled word
      cyc(1'b1, 8'($urandom), 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_keyed = 1'b0; m_ov = 1'b0; m_cnt = 0;
      chk("rst_mid_out_valid", a_out_valid, 0);
      chk("rst_mid_wc", a_wc, 0);
      chk("rst_mid_keyed", a_keyed, 0);
      chk("rst_mid_out_data", a_out_data, 0);

      // rekey limit of four on instance R
      rs = $urandom;
      r_key_load = 1'b1;
      r_key = rs;
      tick();
      r_key_load = 1'b0;
      r_out_ready = 1'b1;
      r_in_valid = 1'b1;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         r_in_data = 8'($urandom);
         #1;
         if (r_in_ready) begin
            acc++;
            rexp = r_in_data ^ rs[7:0];
            rs = ks_next(rs);
            tick();
            chk("rekey_out_data", r_out_data, rexp);
         end else begin
            tick();
         end
      end
      r_in_valid = 1'b0;
      chk("rekey_accepted", acc, 4);
      chk("rekey_expired", r_expired, 1);
      chk("rekey_keyed", r_keyed, 0);
      chk("rekey_in_ready", r_in_ready, 0);
      chk("rekey_wc", r_wc, 4);
      r_key_load = 1'b1;
      tick();
      r_key_load = 1'b0;
      chk("rekey_reload_keyed", r_keyed, 1);
      chk("rekey_reload_expired", r_expired, 0);
      chk("rekey_reload_wc", r_wc, 0);

      // encrypt through A, decrypt through B with the same key
      foreach (words[i]) words[i] = 8'($urandom);
      rs = $urandom;
      a_key_load = 1'b1; a_key = rs;
      b_key_load = 1'b1; b_key = rs;
      tick();
      a_key_load = 1'b0;
      b_key_load = 1'b0;
      chain = 1'b1;
      idx = 0;
      bound = 0;
      while (got.size() < 16 && bound < 200) begin
         a_in_valid = (idx < 16);
         a_in_data = (idx < 16) ? words[idx] : 8'h00;
         #1;
         if (a_in_valid && a_in_ready) idx++;
         tick();
         if (b_out_valid) got.push_back(b_out_data);
         bound++;
      end
      a_in_valid = 1'b0;
      chk("roundtrip_count", got.size(), 16);
      for (int i = 0; i < 16; i++) begin
         if (i < got.size()) chk("roundtrip_word", got[i], words[i]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/stream_cipher_core.md
STREAM_CIPHER_CORE -- requirements
Module: stream_cipher_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning stream word width in bits (1..32).
REQ-002 SHALL have parameter LFSR_W, default 32, meaning keystream LFSR state width (DATA_W..64).
REQ-003 SHALL have parameter POLY, default 32'h8020_0003, meaning Galois feedback mask, LFSR_W bits.
REQ-004 SHALL have parameter REKEY_LIMIT, default 0, meaning words accepted per key before expiry; 0 disables expiry.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port key_load  input  1  load key as LFSR seed this cycle.
REQ-008 SHALL have port key  input  LFSR_W  seed value, sampled when key_load=1.
REQ-009 SHALL have port in_valid  input  1  in_data valid.
REQ-010 SHALL have port in_ready  output  1  core accepts in_data this cycle.
REQ-011 SHALL have port in_data  input  DATA_W  plaintext or ciphertext word.
REQ-012 SHALL have port out_valid  output  1  out_data valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-014 SHALL have port out_data  output  DATA_W  in_data XOR keystream word.
REQ-015 SHALL have port keyed  output  1  core is in KEYED state.
REQ-016 SHALL have port expired  output  1  core is in EXPIRED state.
REQ-017 SHALL have port word_count  output  16  words accepted since last key load, saturating at 16'hFFFF.

Function
REQ-018 SHALL implement FSM states UNKEYED, KEYED, EXPIRED; keyed=1 only in KEYED, expired=1 only in EXPIRED.
REQ-019 SHALL transition any state -> KEYED on key_load=1, loading seed=key, or seed=1 when key==0 (lock-up avoidance).
REQ-020 SHALL define one LFSR step as: b=s[0]; s=s>>1; if b then s=s^POLY.
REQ-021 SHALL form the keystream word as s[DATA_W-1:0] before advancing; each accepted word advances s by exactly DATA_W steps in one cycle.
REQ-022 SHALL assert in_ready = keyed and (not out_valid or out_ready) and not key_load.
REQ-023 SHALL accept a word when in_valid and in_ready; register out_data = in_data ^ keystream and set out_valid on the next edge (latency 1 cycle).
REQ-024 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL clear out_valid after an out_ready handshake with no simultaneous accept; simultaneous handshake plus accept SHALL sustain one word per cycle.
REQ-026 SHALL, on key_load, clear out_valid (pending word discarded), reset word_count to 0, and accept no input that cycle.
REQ-027 SHALL increment word_count on each accept, saturating at 16'hFFFF.
REQ-028 SHALL, when REKEY_LIMIT>0 and an accept makes word_count equal REKEY_LIMIT, move to EXPIRED on that edge; EXPIRED forces in_ready=0.
REQ-029 SHALL let a pending output word drain normally in EXPIRED.
REQ-030 SHALL leave LFSR state unchanged in cycles with no accept.
REQ-031 SHALL produce identical behaviour for encrypt and decrypt; same key and word sequence SHALL invert itself.

Reset
REQ-032 SHALL, with rst=1 at a rising edge, set state UNKEYED, LFSR state 0, out_valid=0, out_data=0, word_count=0; in_ready=0, keyed=0, expired=0.
REQ-033 SHALL give rst priority over key_load and all handshakes; reset mid-stream discards the pending word.

Verification
REQ-034 SHALL cover: rst, key_load key=32'hA5A5_5A5A, in_data=8'h00 valid -> one cycle later out_valid=1, out_data=8'h5A, word_count=1.
REQ-035 SHALL cover: key_load key=0, in_data=8'hFF -> out_data=8'hFE (seed substituted with 1).
REQ-036 SHALL cover: out_ready held 0 for 5 cycles with in_valid=1 -> out_data stable, in_ready=0, word_count unchanged; then out_ready=1 continuous -> one word per cycle.
REQ-037 SHALL cover: REKEY_LIMIT=4, 6 words offered -> 4 accepted, expired=1, in_ready=0; key_load -> keyed=1, word_count=0.
REQ-038 SHALL cover: 16 random words through instance A, outputs into instance B with same key -> B output equals original words.
REQ-039 SHALL cover: key_load or rst asserted while out_valid=1, out_ready=0 -> out_valid=0 next cycle, word_count=0.
